// File: rtl/wdog_pkg.sv
// Shared watchdog constants: FSM state codes and default build parameters,
// also used by the decode and register blocks.
package wdog_pkg;

  localparam int WDOG_WIDTH_DEF      = 32;
  localparam int WDOG_RST_CYCLES_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;

endpackage

// File: rtl/wdog_pulse_stretch.sv
// Stretches a one-cycle start request into a registered pulse of exactly
// RST_CYCLES clocks; done flags the last high cycle of the pulse.
module wdog_pulse_stretch #(
  parameter int RST_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic pulse,
  output logic done
);

  localparam logic [7:0] LEN = 8'(RST_CYCLES);

  logic [7:0] cnt;

  // A start arriving while the pulse is already running is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse <= 1'b0;
      cnt   <= 8'd0;
    end else if (pulse) begin
      if (cnt == 8'd1) begin
        pulse <= 1'b0;
        cnt   <= 8'd0;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end else if (start) begin
      pulse <= 1'b1;
      cnt   <= LEN;
    end
  end

  assign done = pulse && (cnt == 8'd1);

endmodule

// File: rtl/wdog_countdown.sv
// Watchdog countdown timer: IDLE/RUN/FIRE FSM driving a stretched reset pulse.
// Define WDOG_PREWARN_EN to add the warn_thr input and the warn_irq output.
module wdog_countdown
  import wdog_pkg::*;
#(
  parameter int WIDTH      = WDOG_WIDTH_DEF,
  parameter int RST_CYCLES = WDOG_RST_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             kick,
  input  logic [WIDTH-1:0] reload,
  input  logic             clr_flag,
`ifdef WDOG_PREWARN_EN
  input  logic [WIDTH-1:0] warn_thr,
  output logic             warn_irq,
`endif
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             wdog_rst,
  output logic             timeout_flag
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic fire_go;
  logic pulse_done;

  // en=0 outranks kick, and kick outranks the timeout
  assign fire_go = (state == ST_RUN) && en && !kick && (count == '0);

  wdog_pulse_stretch #(
    .RST_CYCLES(RST_CYCLES)
  ) u_pulse (
    .clk  (clk),
    .rst_n(rst_n),
    .start(fire_go),
    .pulse(wdog_rst),
    .done (pulse_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            state <= ST_RUN;
            count <= reload;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (kick) begin
            count <= reload;
          end else if (count == '0) begin
            state <= ST_FIRE;
          end else begin
            count <= count - ONE;
          end
        end
        ST_FIRE: begin
          if (pulse_done) begin
            state <= ST_IDLE;
            count <= reload;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A new timeout beats a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_flag <= 1'b0;
    end else if (fire_go) begin
      timeout_flag <= 1'b1;
    end else if (clr_flag) begin
      timeout_flag <= 1'b0;
    end
  end

`ifdef WDOG_PREWARN_EN
  // Only asserted while the FSM stays in RUN without a reload next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warn_irq <= 1'b0;
    end else begin
      warn_irq <= (state == ST_RUN) && en && !kick && (count != '0) &&
                  (count <= warn_thr);
    end
  end
`endif

endmodule

// File: tb/tb_wdog_countdown.sv
// Directed self-checking bench for wdog_countdown (default parameters).
module tb_wdog_countdown;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        kick;
  logic [31:0] reload;
  logic        clr_flag;
  logic [31:0] count;
  logic [1:0]  state;
  logic        wdog_rst;
  logic        timeout_flag;
`ifdef WDOG_PREWARN_EN
  logic [31:0] warn_thr;
  logic        warn_irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wdog_countdown dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .kick        (kick),
    .reload      (reload),
    .clr_flag    (clr_flag),
`ifdef WDOG_PREWARN_EN
    .warn_thr    (warn_thr),
    .warn_irq    (warn_irq),
`endif
    .count       (count),
    .state       (state),
    .wdog_rst    (wdog_rst),
    .timeout_flag(timeout_flag)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog_timeout observed=hang expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int exp_cnt;
    int min_cnt;
    logic saw_rst;

    rst_n = 1'b0; en = 1'b0; kick = 1'b0; reload = 32'd0; clr_flag = 1'b0;
`ifdef WDOG_PREWARN_EN
    warn_thr = 32'd0;
`endif
    tick(3);
    check_output("rst_state", 32'(state), 32'd0);
    check_output("rst_count", count, 32'd0);
    check_output("rst_wdog", 32'(wdog_rst), 32'd0);
    check_output("rst_flag", 32'(timeout_flag), 32'd0);
    rst_n = 1'b1;

    // RELOAD=5: fire 6 cycles after RUN entry, 16-cycle pulse
    reload = 32'd5; en = 1'b1;
    tick();
    check_output("entry_state", 32'(state), 32'd1);
    check_output("entry_count", count, 32'd5);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_output("dec_count", count, 32'(5 - k));
      check_output("dec_no_rst", 32'(wdog_rst), 32'd0);
    end
    tick();
    check_output("fire_state", 32'(state), 32'd2);
    check_output("fire_rst", 32'(wdog_rst), 32'd1);
    check_output("fire_flag", 32'(timeout_flag), 32'd1);
    for (int j = 1; j <= 15; j++) begin
      tick();
      check_output("pulse_high", 32'(wdog_rst), 32'd1);
    end
    tick();
    check_output("pulse_end_rst", 32'(wdog_rst), 32'd0);
    check_output("pulse_end_state", 32'(state), 32'd0);
    check_output("pulse_end_count", count, 32'd5);
    check_output("pulse_end_flag", 32'(timeout_flag), 32'd1);
    tick();
    check_output("rerun_state", 32'(state), 32'd1);
    en = 1'b0;
    tick();
    check_output("en_off_state", 32'(state), 32'd0);
    check_output("en_off_count", count, 32'd5);
    clr_flag = 1'b1;
    tick();
    clr_flag = 1'b0;
    check_output("flag_clear", 32'(timeout_flag), 32'd0);

    // RELOAD=10 with a kick every 8 cycles
    reload = 32'd10; en = 1'b1;
    tick();
    exp_cnt = 10; min_cnt = 10; saw_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      kick = (i % 8 == 7);
      tick();
      exp_cnt = kick ? 10 : exp_cnt - 1;
      check_output("kick_count", count, 32'(exp_cnt));
      if (int'(count) < min_cnt) min_cnt = int'(count);
      if (wdog_rst) saw_rst = 1'b1;
    end
    kick = 1'b0;
    check_output("kick_never_rst", 32'(saw_rst), 32'd0);
    check_output("kick_min_ge2", 32'(min_cnt >= 2), 32'd1);
    en = 1'b0;
    tick();

    // RELOAD=3: kick at COUNT==0 reloads; kick with en=0 goes IDLE
    reload = 32'd3; en = 1'b1;
    tick(4);
    check_output("zero_count", count, 32'd0);
    kick = 1'b1;
    tick();
    kick = 1'b0;
    check_output("zero_kick_count", count, 32'd3);
    check_output("zero_kick_state", 32'(state), 32'd1);
    check_output("zero_kick_rst", 32'(wdog_rst), 32'd0);
    tick(3);
    kick = 1'b1; en = 1'b0;
    tick();
    kick = 1'b0;
    check_output("kick_en0_state", 32'(state), 32'd0);
    check_output("kick_en0_count", count, 32'd0);
    check_output("kick_en0_rst", 32'(wdog_rst), 32'd0);

    // RELOAD changes mid-RUN only apply at the next load
    en = 1'b1;
    tick();
    reload = 32'd7;
    tick();
    check_output("reload_late", count, 32'd2);
    kick = 1'b1;
    tick();
    kick = 1'b0;
    check_output("reload_kick", count, 32'd7);
    en = 1'b0;
    tick();

    // RELOAD=0 fires after one cycle; clear coincident with set loses
    reload = 32'd0; en = 1'b1;
    tick();
    check_output("r0_count", count, 32'd0);
    clr_flag = 1'b1;
    tick();
    clr_flag = 1'b0;
    check_output("r0_fire_rst", 32'(wdog_rst), 32'd1);
    check_output("set_beats_clr", 32'(timeout_flag), 32'd1);
    kick = 1'b1; en = 1'b0;
    tick();
    kick = 1'b0; en = 1'b1;
    check_output("fire_ignores_in", 32'(state), 32'd2);
    tick(2);
    check_output("fire_4cyc_rst", 32'(wdog_rst), 32'd1);
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_wdog", 32'(wdog_rst), 32'd0);
    check_output("async_rst_state", 32'(state), 32'd0);
    check_output("async_rst_flag", 32'(timeout_flag), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick();
    check_output("post_rst_state", 32'(state), 32'd0);

`ifdef WDOG_PREWARN_EN
    reload = 32'd20; warn_thr = 32'd4; en = 1'b1;
    tick(17);
    check_output("warn_cnt4", count, 32'd4);
    check_output("warn_lag", 32'(warn_irq), 32'd0);
    tick();
    check_output("warn_set", 32'(warn_irq), 32'd1);
    kick = 1'b1;
    tick();
    kick = 1'b0;
    check_output("warn_kick_clr", 32'(warn_irq), 32'd0);
    en = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
